rom_loader: RTL and testbench

- Sequencer that walks every cell of the Game-of-Life field once, in raster order, after a start pulse.
- Drives the (x, y) cell address that fetches the initial pattern from ROM into the field memory.
- Flags the active load window on o_is_loading.
- Sits between the top-level control FSM (issues i_go) and the ROM/field-RAM address muxes.

---
 rtl/rom_loader_if.sv | 28 ++
 rtl/rom_loader.sv | 72 +++++++
 tb/tb_rom_loader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rom_loader_if.sv
// Control-side bundle of the ROM loader: the start request from the control FSM
// and the registered load flag plus (x, y) cell address toward the ROM/field-RAM muxes.
interface rom_loader_if #(
  parameter int FIELD_W = 32,
  parameter int FIELD_H = 32
);
  localparam int X_ADR_SIZE = $clog2(FIELD_W);
  localparam int Y_ADR_SIZE = $clog2(FIELD_H);

  logic                  i_go;
  logic                  o_is_loading;
  logic [X_ADR_SIZE-1:0] o_cur_x;
  logic [Y_ADR_SIZE-1:0] o_cur_y;

  modport master (
    output i_go,
    input  o_is_loading,
    input  o_cur_x,
    input  o_cur_y
  );

  modport slave (
    input  i_go,
    output o_is_loading,
    output o_cur_x,
    output o_cur_y
  );
endinterface

// File: rtl/rom_loader.sv
// Raster-order sweep of every field cell after a start request, presenting one
// (x, y) address per cycle while is_loading is high; all outputs are registered.
module rom_loader #(
  parameter int FIELD_W = 32,
  parameter int FIELD_H = 32
) (
  input logic         clk,
  input logic         rst,
  rom_loader_if.slave bus
);
  localparam int X_ADR_SIZE = $clog2(FIELD_W);
  localparam int Y_ADR_SIZE = $clog2(FIELD_H);
  localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t                state_r;
  logic                  loading_r;
  logic [X_ADR_SIZE-1:0] x_r;
  logic [Y_ADR_SIZE-1:0] y_r;

  // Sweep sequencer; wrap compares against the last index so non-power-of-two sizes never overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      loading_r <= 1'b0;
      x_r       <= '0;
      y_r       <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          x_r <= '0;
          y_r <= '0;
          if (bus.i_go) begin
            state_r   <= LOAD;
            loading_r <= 1'b1;
          end else begin
            state_r   <= IDLE;
            loading_r <= 1'b0;
          end
        end
        LOAD: begin
          if (x_r != X_LAST) begin
            x_r <= x_r + X_ADR_SIZE'(1);
          end else if (y_r != Y_LAST) begin
            x_r <= '0;
            y_r <= y_r + Y_ADR_SIZE'(1);
          end else begin
            state_r   <= IDLE;
            loading_r <= 1'b0;
            x_r       <= '0;
            y_r       <= '0;
          end
        end
        default: begin
          state_r   <= IDLE;
          loading_r <= 1'b0;
          x_r       <= '0;
          y_r       <= '0;
        end
      endcase
    end
  end

  assign bus.o_is_loading = loading_r;
  assign bus.o_cur_x      = x_r;
  assign bus.o_cur_y      = y_r;
endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader on a 5x3 field: expected (is_loading, x, y)
// triples are queued as stimulus is driven and compared one per cycle.
module tb_rom_loader;
  localparam int FW = 5;
  localparam int FH = 3;
  localparam int XW = $clog2(FW);
  localparam int YW = $clog2(FH);

  typedef struct packed {
    logic          ld;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;
  obs_t exp_q[$];

  rom_loader_if #(.FIELD_W(FW), .FIELD_H(FH)) bus ();
  rom_loader #(.FIELD_W(FW), .FIELD_H(FH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic obs_t cur();
    return obs_t'({bus.o_is_loading, bus.o_cur_x, bus.o_cur_y});
  endfunction

  // An empty queue yields an impossible triple so a missing expectation still fails
  function automatic obs_t next_exp();
    if (exp_q.size() > 0) return exp_q.pop_front();
    return '1;
  endfunction

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('0);
  endtask

  task automatic push_sweep();
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++)
        exp_q.push_back(obs_t'({1'b1, XW'(x), YW'(y)}));
    push_idle(1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    rst = 1'b1;
    bus.i_go = 1'b0;
    #1;
    o = cur();
    tests_run++;
    if (o !== obs_t'('0)) begin
      tests_failed++;
      $display("FAIL reset_hold: got %0b/%0d/%0d want 0/0/0", o.ld, o.x, o.y);
    end
    tick();
    rst = 1'b0;
    push_idle(10);
    for (int c = 0; c < 10; c++) begin
      tick();
      e = next_exp(); o = cur(); tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL reset_idle cyc %0d: got %0b/%0d/%0d want %0b/%0d/%0d", c, o.ld, o.x, o.y, e.ld, e.x, e.y);
      end
    end
  endtask

  task automatic test_full_sweep();
    obs_t e, o;
    bus.i_go = 1'b1;
    push_sweep();
    for (int c = 0; c < FW * FH + 1; c++) begin
      tick();
      bus.i_go = 1'b0;
      e = next_exp(); o = cur(); tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL full_sweep cyc %0d: got %0b/%0d/%0d want %0b/%0d/%0d", c, o.ld, o.x, o.y, e.ld, e.x, e.y);
      end
    end
  endtask

  task automatic test_repeated();
    obs_t e, o;
    int gap;
    for (int s = 0; s < 3; s++) begin
      gap = $urandom_range(1, 10);
      push_idle(gap);
      for (int c = 0; c < gap; c++) begin
        tick();
        e = next_exp(); o = cur(); tests_run++;
        if (o !== e) begin
          tests_failed++;
          $display("FAIL repeat_gap s%0d cyc %0d: got %0b/%0d/%0d want %0b/%0d/%0d", s, c, o.ld, o.x, o.y, e.ld, e.x, e.y);
        end
      end
      bus.i_go = 1'b1;
      push_sweep();
      for (int c = 0; c < FW * FH + 1; c++) begin
        tick();
        bus.i_go = 1'b0;
        e = next_exp(); o = cur(); tests_run++;
        if (o !== e) begin
          tests_failed++;
          $display("FAIL repeat_sweep s%0d cyc %0d: got %0b/%0d/%0d want %0b/%0d/%0d", s, c, o.ld, o.x, o.y, e.ld, e.x, e.y);
        end
      end
    end
  endtask

  task automatic test_go_during_load();
    obs_t e, o;
    bus.i_go = 1'b1;
    push_sweep();
    push_idle(4);
    for (int c = 0; c < FW * FH + 5; c++) begin
      tick();
      e = next_exp(); o = cur(); tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL go_in_load cyc %0d: got %0b/%0d/%0d want %0b/%0d/%0d", c, o.ld, o.x, o.y, e.ld, e.x, e.y);
      end
      // Raise go while cells (2,1) and (4,2) are presented; it must be ignored
      bus.i_go = (c == 7 || c == 14) ? 1'b1 : 1'b0;
    end
  endtask

  task automatic test_reset_mid_sweep();
    obs_t e, o;
    bus.i_go = 1'b1;
    push_sweep();
    for (int c = 0; c < 9; c++) begin
      tick();
      bus.i_go = 1'b0;
      e = next_exp(); o = cur(); tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL midrst_pre cyc %0d: got %0b/%0d/%0d want %0b/%0d/%0d", c, o.ld, o.x, o.y, e.ld, e.x, e.y);
      end
    end
    rst = 1'b1;
    #1;
    o = cur(); tests_run++;
    if (o !== obs_t'('0)) begin
      tests_failed++;
      $display("FAIL midrst_async: got %0b/%0d/%0d want 0/0/0", o.ld, o.x, o.y);
    end
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    push_idle(5);
    for (int c = 0; c < 5; c++) begin
      tick();
      e = next_exp(); o = cur(); tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL midrst_idle cyc %0d: got %0b/%0d/%0d want %0b/%0d/%0d", c, o.ld, o.x, o.y, e.ld, e.x, e.y);
      end
    end
    bus.i_go = 1'b1;
    push_sweep();
    for (int c = 0; c < FW * FH + 1; c++) begin
      tick();
      bus.i_go = 1'b0;
      e = next_exp(); o = cur(); tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL midrst_sweep cyc %0d: got %0b/%0d/%0d want %0b/%0d/%0d", c, o.ld, o.x, o.y, e.ld, e.x, e.y);
      end
    end
  endtask

  task automatic test_held_go();
    obs_t e, o;
    bus.i_go = 1'b1;
    // 40 sampling edges with go high: sweeps start on edges 1, 17 and 33
    for (int s = 0; s < 3; s++) push_sweep();
    push_idle(3);
    for (int c = 0; c < 3 * (FW * FH + 1) + 3; c++) begin
      tick();
      if (c == 39) bus.i_go = 1'b0;
      e = next_exp(); o = cur(); tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL held_go cyc %0d: got %0b/%0d/%0d want %0b/%0d/%0d", c, o.ld, o.x, o.y, e.ld, e.x, e.y);
      end
    end
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_sweep();
    test_repeated();
    test_go_during_load();
    test_reset_mid_sweep();
    test_held_go();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
